android2fpga_pio_arbiter: RTL and testbench

// - Two-requester round-robin arbiter sharing one 8-bit PIO Avalon-MM slave (LED/out_port register).
// - Requester 0: Android bridge master. Requester 1: local FPGA sequencer.
// - Serialises single-word reads/writes onto the PIO slave port; stalls the loser via waitrequest.
// - Sits between the interconnect masters and the PIO s1 slave.

---
 rtl/android2fpga_pkg.sv | 19 +
 rtl/android2fpga_pio_arbiter_rr_arb2.sv | 13 +
 rtl/android2fpga_pio_arbiter.sv | 121 ++++++++++++
 tb/tb_android2fpga_pio_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/android2fpga_pkg.sv
// Shared definitions for the Android-to-FPGA PIO sharing logic: FSM encodings,
// PIO bus widths and the Avalon request decode.
package android2fpga_pkg;

  localparam int unsigned PIO_ADDR_W = 2;
  localparam int unsigned PIO_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  // A requester wants the bus when selected with either strobe active.
  function automatic logic req_active(input logic cs, input logic write_n, input logic read_n);
    return cs & (~write_n | ~read_n);
  endfunction

endpackage

// File: rtl/android2fpga_pio_arbiter_rr_arb2.sv
// Two-way round-robin pick: a sole requester wins, a tie goes to the requester
// that was not granted last. Purely combinational so other shared slaves can reuse it.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       any_req,
  output logic       winner
);

  assign any_req = |req;
  assign winner  = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/android2fpga_pio_arbiter.sv
// Round-robin arbiter sharing one PIO Avalon-MM slave between the Android bridge
// (m0) and the local sequencer (m1); one non-pipelined transfer every three cycles.
module android2fpga_pio_arbiter
  import android2fpga_pkg::*;
#(
  parameter int unsigned ADDR_W = PIO_ADDR_W,
  parameter int unsigned DATA_W = PIO_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_chipselect,
  input  logic              m0_write_n,
  input  logic              m0_read_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,
  input  logic              m1_chipselect,
  input  logic              m1_write_n,
  input  logic              m1_read_n,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,
  output logic              pio_chipselect,
  output logic              pio_write_n,
  output logic [ADDR_W-1:0] pio_address,
  output logic [DATA_W-1:0] pio_writedata,
  input  logic [DATA_W-1:0] pio_readdata
);

  arb_state_e        state_q;
  logic              grant_q;
  logic              last_grant_q;
  logic              wr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              pio_chipselect_q;
  logic              pio_write_n_q;
  logic [ADDR_W-1:0] pio_address_q;
  logic [DATA_W-1:0] pio_writedata_q;

  logic              req0;
  logic              req1;
  logic              any_req;
  logic              winner;
  logic              cmd_wr_d;
  logic [ADDR_W-1:0] cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_d;

  assign req0 = req_active(m0_chipselect, m0_write_n, m0_read_n);
  assign req1 = req_active(m1_chipselect, m1_write_n, m1_read_n);

  rr_arb2 u_rr_arb2 (
    .req        ({req1, req0}),
    .last_grant (last_grant_q),
    .any_req    (any_req),
    .winner     (winner)
  );

  // Command of the winning requester; an active write strobe overrides a read.
  assign cmd_wr_d    = winner ? ~m1_write_n  : ~m0_write_n;
  assign cmd_addr_d  = winner ? m1_address   : m0_address;
  assign cmd_wdata_d = winner ? m1_writedata : m0_writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      grant_q          <= 1'b0;
      last_grant_q     <= 1'b1;
      wr_q             <= 1'b0;
      rdata_q          <= '0;
      pio_chipselect_q <= 1'b0;
      pio_write_n_q    <= 1'b1;
      pio_address_q    <= '0;
      pio_writedata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            state_q          <= ST_ISSUE;
            grant_q          <= winner;
            last_grant_q     <= winner;
            wr_q             <= cmd_wr_d;
            pio_chipselect_q <= 1'b1;
            pio_write_n_q    <= ~cmd_wr_d;
            pio_address_q    <= cmd_addr_d;
            pio_writedata_q  <= cmd_wdata_d;
          end
        end
        ST_ISSUE: begin
          // Zero-latency slave: read data is valid while chipselect is high.
          if (!wr_q) begin
            rdata_q <= pio_readdata;
          end
          pio_chipselect_q <= 1'b0;
          pio_write_n_q    <= 1'b1;
          state_q          <= ST_RESP;
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign pio_chipselect = pio_chipselect_q;
  assign pio_write_n    = pio_write_n_q;
  assign pio_address    = pio_address_q;
  assign pio_writedata  = pio_writedata_q;

  // Release only the grantee, and only for its single response cycle.
  assign m0_waitrequest = ~((state_q == ST_RESP) & ~grant_q);
  assign m1_waitrequest = ~((state_q == ST_RESP) &  grant_q);

  assign m0_readdata = rdata_q;
  assign m1_readdata = rdata_q;

endmodule

// File: tb/tb_android2fpga_pio_arbiter.sv
// Bench for android2fpga_pio_arbiter: queued Avalon master models, a PIO slave
// model and a transaction-level arbitration reference.
module tb_android2fpga_pio_arbiter;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic          wr;
    logic          rd_too;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_chipselect, m0_write_n, m0_read_n, m0_waitrequest;
  logic [AW-1:0] m0_address;
  logic [DW-1:0] m0_writedata, m0_readdata;
  logic          m1_chipselect, m1_write_n, m1_read_n, m1_waitrequest;
  logic [AW-1:0] m1_address;
  logic [DW-1:0] m1_writedata, m1_readdata;
  logic          pio_chipselect, pio_write_n;
  logic [AW-1:0] pio_address;
  logic [DW-1:0] pio_writedata, pio_readdata;

  always #5 clk = ~clk;

  android2fpga_pio_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .m0_chipselect  (m0_chipselect),
    .m0_write_n     (m0_write_n),
    .m0_read_n      (m0_read_n),
    .m0_address     (m0_address),
    .m0_writedata   (m0_writedata),
    .m0_readdata    (m0_readdata),
    .m0_waitrequest (m0_waitrequest),
    .m1_chipselect  (m1_chipselect),
    .m1_write_n     (m1_write_n),
    .m1_read_n      (m1_read_n),
    .m1_address     (m1_address),
    .m1_writedata   (m1_writedata),
    .m1_readdata    (m1_readdata),
    .m1_waitrequest (m1_waitrequest),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_address    (pio_address),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata)
  );

  // PIO slave: register file reset with the system, combinational readback.
  logic [DW-1:0] pio_mem [4];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) pio_mem[i] <= '0;
    end else if (pio_chipselect && !pio_write_n) begin
      pio_mem[pio_address] <= pio_writedata;
    end
  end
  assign pio_readdata = pio_mem[pio_address];

  op_t  q0[$];
  op_t  q1[$];
  int   comp_id[$];
  int   comp_cyc[$];
  logic [DW-1:0] comp_rdata[$];
  int   cyc;
  int   n_assert;
  int   n_fail;

  // Reference: cycles since the grant decision (0 = bus free), owner and tie history.
  int            age;
  int            owner;
  int            prev;
  op_t           cur;
  logic [DW-1:0] ref_mem [4];
  logic [DW-1:0] ref_rdata;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive();
    if (q0.size() > 0) begin
      m0_chipselect = 1'b1;
      m0_write_n    = ~q0[0].wr;
      m0_read_n     = q0[0].wr ? ~q0[0].rd_too : 1'b0;
      m0_address    = q0[0].addr;
      m0_writedata  = q0[0].data;
    end else begin
      m0_chipselect = 1'b0; m0_write_n = 1'b1; m0_read_n = 1'b1;
      m0_address    = AW'($urandom); m0_writedata = $urandom;
    end
    if (q1.size() > 0) begin
      m1_chipselect = 1'b1;
      m1_write_n    = ~q1[0].wr;
      m1_read_n     = q1[0].wr ? ~q1[0].rd_too : 1'b0;
      m1_address    = q1[0].addr;
      m1_writedata  = q1[0].data;
    end else begin
      m1_chipselect = 1'b0; m1_write_n = 1'b1; m1_read_n = 1'b1;
      m1_address    = AW'($urandom); m1_writedata = $urandom;
    end
  endtask

  task automatic model_reset();
    age = 0; owner = 0; prev = 1; ref_rdata = '0;
    for (int i = 0; i < 4; i++) ref_mem[i] = '0;
  endtask

  // One clock cycle: drive, check against the reference, advance the reference.
  task automatic step();
    bit r0, r1;
    int w;
    drive();
    chk("pio_chipselect", DW'(pio_chipselect), DW'(age == 1));
    chk("pio_write_n", DW'(pio_write_n), DW'(!(age == 1 && cur.wr)));
    if (age == 1) begin
      chk("pio_address", DW'(pio_address), DW'(cur.addr));
      if (cur.wr) chk("pio_writedata", pio_writedata, cur.data);
    end
    chk("m0_waitrequest", DW'(m0_waitrequest), DW'(!(age == 2 && owner == 0)));
    chk("m1_waitrequest", DW'(m1_waitrequest), DW'(!(age == 2 && owner == 1)));
    if (age == 2) chk("readdata", (owner == 1) ? m1_readdata : m0_readdata, ref_rdata);

    r0 = q0.size() > 0;
    r1 = q1.size() > 0;
    if (reset) begin
      model_reset();
    end else if (age == 1) begin
      if (cur.wr) ref_mem[cur.addr] = cur.data;
      else        ref_rdata = ref_mem[cur.addr];
      age = 2;
    end else if (age == 2) begin
      age = 0;
    end else if (r0 || r1) begin
      w     = (r0 && r1) ? 1 - prev : (r1 ? 1 : 0);
      prev  = w;
      owner = w;
      cur   = (w == 1) ? q1[0] : q0[0];
      age   = 1;
    end

    if (!m0_waitrequest && q0.size() > 0) begin
      void'(q0.pop_front());
      comp_id.push_back(0); comp_cyc.push_back(cyc); comp_rdata.push_back(m0_readdata);
    end
    if (!m1_waitrequest && q1.size() > 0) begin
      void'(q1.pop_front());
      comp_id.push_back(1); comp_cyc.push_back(cyc); comp_rdata.push_back(m1_readdata);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete();
    reset = 1'b1;
    drive();
    @(negedge clk);
    cyc++;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic run(input int max_cyc);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || age != 0) && n < max_cyc) begin
      step();
      n++;
    end
    chk("run_bound", DW'(n < max_cyc), DW'(1));
  endtask

  task automatic clear_log();
    comp_id.delete(); comp_cyc.delete(); comp_rdata.delete();
  endtask

  function automatic op_t mk(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    op_t o;
    o.wr = wr; o.rd_too = 1'b0; o.addr = addr; o.data = data;
    return o;
  endfunction

  initial begin
    int start;
    op_t o;
    n_assert = 0; n_fail = 0; cyc = 0;
    cur = '0;
    model_reset();

    // Reset then idle: bus quiet, both stalled, read data cleared.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      chk("idle_m0_readdata", m0_readdata, '0);
      chk("idle_m1_readdata", m1_readdata, '0);
      step();
    end

    // m0 write of 0xA5 to address 0.
    clear_log(); start = cyc;
    q0.push_back(mk(1'b1, 2'd0, 32'h0000_00A5));
    run(20);
    chk("wr_done_count", DW'(comp_id.size()), DW'(1));
    chk("wr_latency", DW'(comp_cyc[0] - start), DW'(2));
    chk("wr_out_port", pio_mem[0], 32'h0000_00A5);

    // m1 reads back address 0.
    clear_log(); start = cyc;
    q1.push_back(mk(1'b0, 2'd0, 32'h0));
    run(20);
    chk("rd_done_id", DW'(comp_id[0]), DW'(1));
    chk("rd_latency", DW'(comp_cyc[0] - start), DW'(2));
    chk("rd_data", comp_rdata[0], 32'h0000_00A5);

    // Simultaneous requests straight after reset: m0 first, six cycles total.
    do_reset();
    clear_log(); start = cyc;
    q0.push_back(mk(1'b1, 2'd0, 32'h11));
    q1.push_back(mk(1'b1, 2'd0, 32'h22));
    run(20);
    chk("tie_first", DW'(comp_id[0]), DW'(0));
    chk("tie_second", DW'(comp_id[1]), DW'(1));
    chk("tie_total_cycles", DW'(comp_cyc[1] - start + 1), DW'(6));
    chk("tie_out_port", pio_mem[0], 32'h22);

    // Both held for four transfers each: strict alternation, 3-cycle spacing.
    clear_log(); start = cyc;
    for (int k = 0; k < 4; k++) begin
      q0.push_back(mk(1'b1, 2'd1, DW'(32'h100 + k)));
      q1.push_back(mk(1'b1, 2'd2, DW'(32'h200 + k)));
    end
    run(60);
    chk("b2b_count", DW'(comp_id.size()), DW'(8));
    for (int k = 0; k < comp_id.size() && k < 8; k++) begin
      chk("b2b_grant", DW'(comp_id[k]), DW'(k % 2));
      chk("b2b_cycle", DW'(comp_cyc[k] - start), DW'(3 * k + 2));
    end

    // Reset during ISSUE of an m1 write: transfer dropped, next tie goes to m0.
    do_reset();
    clear_log();
    q1.push_back(mk(1'b1, 2'd0, 32'h33));
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    q1.delete();
    step();
    chk("rst_cs_low", DW'(pio_chipselect), DW'(0));
    chk("rst_m1_wait", DW'(m1_waitrequest), DW'(1));
    chk("rst_no_completion", DW'(comp_id.size()), DW'(0));
    chk("rst_out_port", pio_mem[0], 32'h0);
    q0.push_back(mk(1'b1, 2'd0, 32'h44));
    q1.push_back(mk(1'b1, 2'd0, 32'h55));
    run(20);
    chk("rst_tie_first", DW'(comp_id[0]), DW'(0));
    chk("rst_out_port_final", pio_mem[0], 32'h55);

    // Random traffic from both masters, including write+read strobes together.
    for (int i = 0; i < 400; i++) begin
      if (q0.size() == 0 && $urandom_range(0, 1) == 1) begin
        o = mk(1'($urandom_range(0, 1)), AW'($urandom), $urandom);
        o.rd_too = 1'($urandom_range(0, 1));
        q0.push_back(o);
      end
      if (q1.size() == 0 && $urandom_range(0, 1) == 1) begin
        o = mk(1'($urandom_range(0, 1)), AW'($urandom), $urandom);
        o.rd_too = 1'($urandom_range(0, 1));
        q1.push_back(o);
      end
      step();
    end
    run(40);
    for (int i = 0; i < 4; i++) chk("rand_mem", pio_mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
